// File: rtl/apu_frame_sequencer.sv
// APU frame counter / sequencer.
// Produces quarter-frame and half-frame clock pulses and the frame IRQ from a
// free-running cpu_clk cycle counter that $4017 writes can reconfigure.
// A $4017 write takes effect a few cycles after the strobe. At that point the
// counter restarts and the new mode is applied.
// Optional feature macro: FRAME_IRQ_EN. When it is defined, the sticky frame
// IRQ flag and the irq_inhibit bit are built. When it is undefined, frame_irq
// is tied low.
module apu_frame_sequencer #(
  parameter int STEP1       = 7457,
  parameter int STEP2       = 14913,
  parameter int STEP3       = 22371,
  parameter int STEP4       = 29829,
  parameter int STEP5       = 37281,
  parameter int WRITE_DELAY = 3
) (
  input  logic       cpu_clk,
  input  logic       rst_l,
  input  logic       reg_write,
  input  logic [7:0] reg_data,
  input  logic       status_read,
  output logic       quarter_clk,
  output logic       half_clk,
  output logic       frame_irq,
  output logic       mode
);

  localparam logic [15:0] S1   = 16'(STEP1);
  localparam logic [15:0] S2   = 16'(STEP2);
  localparam logic [15:0] S3   = 16'(STEP3);
  localparam logic [15:0] S4   = 16'(STEP4);
  localparam logic [15:0] S4M1 = 16'(STEP4 - 1);
  localparam logic [15:0] S5   = 16'(STEP5);
  localparam int          DW   = $clog2(WRITE_DELAY + 1);

  logic [15:0]   cyc;
  logic          wrapped;
  logic          pending_mode;
  logic [DW-1:0] delay;

  logic [15:0]   final_step;
  logic          at_final;
  logic          apply;
  logic [15:0]   cyc_next;
  logic          mode_next;
  logic [15:0]   final_next;
  logic          wrap_next;
  logic          quarter_next;
  logic          half_next;

  // A new strobe restarts the delay, so an apply only happens when no write
  // is arriving in the same cycle.
  assign apply = (delay == DW'(1)) && !reg_write;

  // Next counter/mode value and the pulses that go with it. The pulses are
  // decoded from the next count, so the registered pulse lines up with the
  // cycle in which cyc holds the step value.
  always_comb begin
    final_step   = mode ? S5 : S4;
    at_final     = (cyc == final_step);
    cyc_next     = 16'd0;
    mode_next    = mode;
    final_next   = final_step;
    wrap_next    = 1'b0;
    quarter_next = 1'b0;
    half_next    = 1'b0;
    if (apply) begin
      // The restart wins over any step match; a 5-step apply clocks at once.
      mode_next    = pending_mode;
      quarter_next = pending_mode;
      half_next    = pending_mode;
    end else begin
      cyc_next     = at_final ? 16'd0 : cyc + 16'd1;
      wrap_next    = at_final && !mode;
      final_next   = final_step;
      quarter_next = (cyc_next == S1) || (cyc_next == S2) ||
                     (cyc_next == S3) || (cyc_next == final_next);
      half_next    = (cyc_next == S2) || (cyc_next == final_next);
    end
  end

  // Cycle counter, applied mode, wrap marker and registered step pulses.
  always_ff @(posedge cpu_clk or negedge rst_l) begin
    if (!rst_l) begin
      cyc         <= 16'd0;
      mode        <= 1'b0;
      wrapped     <= 1'b0;
      quarter_clk <= 1'b0;
      half_clk    <= 1'b0;
    end else begin
      cyc         <= cyc_next;
      mode        <= mode_next;
      wrapped     <= wrap_next;
      quarter_clk <= quarter_next;
      half_clk    <= half_next;
    end
  end

  // Pending $4017 write: latch the requested mode and count down to apply.
  always_ff @(posedge cpu_clk or negedge rst_l) begin
    if (!rst_l) begin
      pending_mode <= 1'b0;
      delay        <= '0;
    end else if (reg_write) begin
      pending_mode <= reg_data[7];
      delay        <= DW'(WRITE_DELAY);
    end else if (delay != '0) begin
      delay        <= delay - DW'(1);
    end
  end

`ifdef FRAME_IRQ_EN
  logic irq_inhibit;
  logic irq_set;

  // The flag is raised on the last two cycles of a 4-step frame and again on
  // the cycle just after the wrap.
  assign irq_set = !mode && !irq_inhibit &&
                   ((cyc == S4M1) || (cyc == S4) || wrapped);

  // Inhibit bit and sticky IRQ flag. An inhibiting write clears the flag at
  // once. A set in the same cycle beats a status read.
  always_ff @(posedge cpu_clk or negedge rst_l) begin
    if (!rst_l) begin
      irq_inhibit <= 1'b0;
      frame_irq   <= 1'b0;
    end else begin
      if (reg_write) begin
        irq_inhibit <= reg_data[6];
      end
      if (reg_write && reg_data[6]) begin
        frame_irq <= 1'b0;
      end else if (irq_set) begin
        frame_irq <= 1'b1;
      end else if (status_read) begin
        frame_irq <= 1'b0;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, reg_data[5:0]};
`else
  assign frame_irq = 1'b0;

  logic unused_bits;
  assign unused_bits = &{1'b0, reg_data[6:0], status_read, wrapped};
`endif

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed bench for apu_frame_sequencer. It uses shortened step positions so
// that several full frames fit in a short run. Expected frame_irq values
// follow FRAME_IRQ_EN.
module tb_apu_frame_sequencer;

  localparam int S1 = 97;
  localparam int S2 = 193;
  localparam int S3 = 291;
  localparam int S4 = 389;
  localparam int S5 = 487;
  localparam int WD = 3;

`ifdef FRAME_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic       cpu_clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       reg_write = 1'b0;
  logic [7:0] reg_data = 8'h00;
  logic       status_read = 1'b0;
  logic       quarter_clk;
  logic       half_clk;
  logic       frame_irq;
  logic       mode;

  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc_m = 0;
  int   q_cnt = 0;
  int   h_cnt = 0;
  logic m_mode = 1'b0;

  apu_frame_sequencer #(
    .STEP1(S1), .STEP2(S2), .STEP3(S3), .STEP4(S4), .STEP5(S5),
    .WRITE_DELAY(WD)
  ) dut (
    .cpu_clk(cpu_clk),
    .rst_l(rst_l),
    .reg_write(reg_write),
    .reg_data(reg_data),
    .status_read(status_read),
    .quarter_clk(quarter_clk),
    .half_clk(half_clk),
    .frame_irq(frame_irq),
    .mode(mode)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge. Outputs are sampled on the following falling edge, and
  // the expected cycle count is tracked along with the pulses seen.
  task automatic tick();
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    if (cyc_m == (m_mode ? S5 : S4)) cyc_m = 0;
    else cyc_m++;
    if (quarter_clk === 1'b1) q_cnt++;
    if (half_clk === 1'b1) h_cnt++;
  endtask

  task automatic run_to(input int c);
    int budget;
    budget = 0;
    while (cyc_m != c && budget < 2000) begin
      tick();
      budget++;
    end
    if (cyc_m != c) begin
      n_assert++;
      n_fail++;
      $error("FAIL run_to_budget: observed %0d expected %0d", cyc_m, c);
    end
  endtask

  task automatic write_reg(input logic [7:0] d);
    reg_write = 1'b1;
    reg_data  = d;
    tick();
    reg_write = 1'b0;
    reg_data  = 8'h00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    repeat (3) @(negedge cpu_clk);
    chk("rst_quarter", quarter_clk, 0);
    chk("rst_half", half_clk, 0);
    chk("rst_irq", frame_irq, 0);
    chk("rst_mode", mode, 0);
    rst_l = 1'b1;
    cyc_m = 0; q_cnt = 0; h_cnt = 0; m_mode = 1'b0;

    // 1: free-running 4-step frame
    run_to(S1 - 1);
    chk("t1_pre_s1_q", quarter_clk, 0);
    tick();
    chk("t1_s1_q", quarter_clk, 1);
    chk("t1_s1_h", half_clk, 0);
    run_to(S2);
    chk("t1_s2_q", quarter_clk, 1);
    chk("t1_s2_h", half_clk, 1);
    run_to(S3);
    chk("t1_s3_q", quarter_clk, 1);
    chk("t1_s3_h", half_clk, 0);
    run_to(S4 - 2);
    chk("t1_irq_early", frame_irq, 0);
    run_to(S4);
    chk("t1_s4_q", quarter_clk, 1);
    chk("t1_s4_h", half_clk, 1);
    chk("t1_s4_irq", frame_irq, IRQ_ON);
    chk("t1_qcount", q_cnt, 4);
    chk("t1_hcount", h_cnt, 2);
    tick();
    chk("t1_wrap_q", quarter_clk, 0);
    chk("t1_wrap_irq", frame_irq, IRQ_ON);
    run_to(S1);
    chk("t1_f2_s1_q", quarter_clk, 1);
    chk("t1_f2_qcount", q_cnt, 5);

    // 2: status reads against the IRQ set window
    run_to(S4 - 1);
    status_read = 1'b1;
    tick();
    status_read = 1'b0;
    chk("t2_read_s4m1_irq", frame_irq, IRQ_ON);
    tick();
    status_read = 1'b1;
    tick();
    status_read = 1'b0;
    chk("t2_read_wrap_irq", frame_irq, IRQ_ON);
    run_to(40);
    status_read = 1'b1;
    tick();
    status_read = 1'b0;
    chk("t2_read_clear_irq", frame_irq, 0);

    // 3: switch to 5-step mode
    run_to(60);
    write_reg(8'h80);
    tick();
    tick();
    chk("t3_pre_apply_mode", mode, 0);
    chk("t3_pre_apply_q", quarter_clk, 0);
    tick();
    cyc_m = 0; m_mode = 1'b1;
    chk("t3_apply_mode", mode, 1);
    chk("t3_apply_q", quarter_clk, 1);
    chk("t3_apply_h", half_clk, 1);
    q_cnt = 0; h_cnt = 0;
    tick();
    chk("t3_after_apply_q", quarter_clk, 0);
    chk("t3_after_apply_h", half_clk, 0);
    run_to(S1);
    chk("t3_s1_q", quarter_clk, 1);
    chk("t3_s1_h", half_clk, 0);
    run_to(S2);
    chk("t3_s2_q", quarter_clk, 1);
    chk("t3_s2_h", half_clk, 1);
    run_to(S3);
    chk("t3_s3_q", quarter_clk, 1);
    run_to(S4);
    chk("t3_s4_q", quarter_clk, 0);
    chk("t3_s4_h", half_clk, 0);
    chk("t3_s4_irq", frame_irq, 0);
    run_to(S5);
    chk("t3_s5_q", quarter_clk, 1);
    chk("t3_s5_h", half_clk, 1);
    chk("t3_s5_irq", frame_irq, 0);
    chk("t3_qcount", q_cnt, 4);
    chk("t3_hcount", h_cnt, 2);
    tick();
    chk("t3_wrap_q", quarter_clk, 0);

    // 4: irq_inhibit write clears and masks the flag
    run_to(10);
    write_reg(8'h00);
    tick(); tick(); tick();
    cyc_m = 0; m_mode = 1'b0;
    chk("t4_apply4_mode", mode, 0);
    chk("t4_apply4_q", quarter_clk, 0);
    chk("t4_apply4_h", half_clk, 0);
    run_to(S4);
    chk("t4_s4_q", quarter_clk, 1);
    chk("t4_s4_irq", frame_irq, IRQ_ON);
    tick();
    run_to(50);
    chk("t4_pre_inhibit_irq", frame_irq, IRQ_ON);
    write_reg(8'h40);
    chk("t4_inhibit_clear", frame_irq, 0);
    tick(); tick(); tick();
    cyc_m = 0;
    run_to(S4);
    chk("t4_inhibited_s4_irq", frame_irq, 0);
    chk("t4_inhibited_s4_q", quarter_clk, 1);
    tick(); tick();
    chk("t4_inhibited_wrap_irq", frame_irq, 0);
    run_to(10);
    write_reg(8'h00);
    tick(); tick(); tick();
    cyc_m = 0;
    run_to(S4);
    chk("t4_resume_irq", frame_irq, IRQ_ON);

    // 5: apply coinciding with the first step, then a superseded write
    tick();
    run_to(S1 - 4);
    write_reg(8'h80);
    q_cnt = 0; h_cnt = 0;
    tick(); tick();
    chk("t5_pre_mode", mode, 0);
    chk("t5_pre_q", quarter_clk, 0);
    tick();
    cyc_m = 0; m_mode = 1'b1;
    chk("t5_coincide_q", quarter_clk, 1);
    chk("t5_coincide_h", half_clk, 1);
    chk("t5_coincide_mode", mode, 1);
    chk("t5_coincide_qcount", q_cnt, 1);
    tick();
    chk("t5_after_q", quarter_clk, 0);
    chk("t5_after_h", half_clk, 0);
    run_to(20);
    write_reg(8'h80);
    write_reg(8'h00);
    tick(); tick();
    chk("t5_restart_mode", mode, 1);
    tick();
    cyc_m = 0; m_mode = 1'b0;
    chk("t5_second_mode", mode, 0);
    chk("t5_second_q", quarter_clk, 0);
    chk("t5_second_h", half_clk, 0);
    q_cnt = 0; h_cnt = 0;
    run_to(S1);
    chk("t5_s1_q", quarter_clk, 1);
    chk("t5_s1_qcount", q_cnt, 1);

    // 6: asynchronous reset mid-frame and while a write is pending
    run_to(S2);
    chk("t6_s2_q", quarter_clk, 1);
    chk("t6_s2_h", half_clk, 1);
    rst_l = 1'b0;
    #1;
    chk("t6_rst_q", quarter_clk, 0);
    chk("t6_rst_h", half_clk, 0);
    chk("t6_rst_irq", frame_irq, 0);
    chk("t6_rst_mode", mode, 0);
    @(negedge cpu_clk);
    rst_l = 1'b1;
    cyc_m = 0; m_mode = 1'b0;
    run_to(5);
    write_reg(8'h80);
    tick();
    rst_l = 1'b0;
    #1;
    chk("t6_pend_rst_q", quarter_clk, 0);
    chk("t6_pend_rst_mode", mode, 0);
    @(negedge cpu_clk);
    rst_l = 1'b1;
    cyc_m = 0; q_cnt = 0; h_cnt = 0;
    run_to(20);
    chk("t6_discarded_mode", mode, 0);
    chk("t6_discarded_qcount", q_cnt, 0);
    run_to(S1);
    chk("t6_s1_q", quarter_clk, 1);
    chk("t6_s1_h", half_clk, 0);
    chk("t6_s1_qcount", q_cnt, 1);
    chk("t6_s1_mode", mode, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
